chroma_fade_sequencer: RTL and testbench

- Nios-programmable controller for the chroma-key blend stage. It drives the 10-bit transparency and green-threshold inputs of the blend datapath.
- Ramps transparency from its current value to a programmed target, one step per N frames.
- Updates are applied only on the VGA vertical-sync edge, so a frame never shows two alpha values.
- Sits between the Avalon-MM bus (simple slave, no waitrequest) and the chroma blend datapath.

---
 rtl/chroma_fade_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_chroma_fade_sequencer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chroma_fade_sequencer.sv
// chroma_fade_sequencer: bus-programmable alpha fade and green-threshold
// controller for the chroma-key blend stage. Alpha and threshold changes are
// applied only on the vsync falling edge, so each frame sees a single value.
module chroma_fade_sequencer #(
  parameter logic [9:0] ALPHA_RST = 10'h3FF,
  parameter logic [9:0] THR_RST   = 10'h1FF
) (
  input  logic        iCLK27,
  input  logic        iRST_N,
  input  logic        iVSYNC_N,
  input  logic [1:0]  iAddress,
  input  logic        iWrite,
  input  logic [31:0] iWriteData,
  input  logic        iRead,
  output logic [31:0] oReadData,
  output logic [9:0]  oTransparencia,
  output logic [9:0]  oThreshold,
  output logic        oBusy,
  output logic        oIrq
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state, w_state_nxt;

  // programmed registers
  logic [9:0]  r_target, r_step, r_thr;
  logic [7:0]  r_div;
  logic        r_irq_en, r_irq_pend;
  // parameters latched at start, so mid-run writes do not disturb the fade
  logic [9:0]  r_act_target, r_act_step;
  logic [7:0]  r_act_div;
  logic [7:0]  r_frame_cnt;
  logic [9:0]  r_alpha, r_thr_out;
  logic [31:0] r_rdata;

  logic r_vs_meta, r_vs_sync, r_vs_prev;
  logic w_frame_tick;

  logic w_wr_ctrl, w_start, w_abort, w_irq_clr;
  logic w_capture, w_apply, w_cnt_inc, w_set_pend;
  logic w_div_hit, w_up;
  logic [10:0] w_sum, w_dif;
  logic [9:0]  w_alpha_step;

  // vsync is idle high, so the synchroniser resets high to avoid a false tick
  always_ff @(posedge iCLK27 or negedge iRST_N) begin
    if (!iRST_N) begin
      r_vs_meta <= 1'b1;
      r_vs_sync <= 1'b1;
      r_vs_prev <= 1'b1;
    end else begin
      r_vs_meta <= iVSYNC_N;
      r_vs_sync <= r_vs_meta;
      r_vs_prev <= r_vs_sync;
    end
  end

  assign w_frame_tick = r_vs_prev & ~r_vs_sync;

  assign w_wr_ctrl = iWrite && (iAddress == 2'd0);
  assign w_abort   = w_wr_ctrl & iWriteData[1];
  assign w_start   = w_wr_ctrl & iWriteData[0] & ~iWriteData[1];
  assign w_irq_clr = w_wr_ctrl & iWriteData[3];

  // one saturating step toward the target; 11-bit math catches over/underflow
  always_comb begin
    w_sum = {1'b0, r_alpha} + {1'b0, r_act_step};
    w_dif = {1'b0, r_alpha} - {1'b0, r_act_step};
    w_up  = r_act_target > r_alpha;
    if (w_up)
      w_alpha_step = (w_sum > {1'b0, r_act_target}) ? r_act_target : w_sum[9:0];
    else
      w_alpha_step = (w_dif[10] || (w_dif[9:0] < r_act_target)) ? r_act_target : w_dif[9:0];
  end

  assign w_div_hit = (r_frame_cnt == (r_act_div - 8'd1));

  // FSM state register
  always_ff @(posedge iCLK27 or negedge iRST_N) begin
    if (!iRST_N) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // FSM next state and datapath controls; abort overrides everything
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_apply     = 1'b0;
    w_cnt_inc   = 1'b0;
    w_set_pend  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_capture   = 1'b1;
          w_state_nxt = (r_target == r_alpha) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (w_frame_tick) begin
          if (w_div_hit) begin
            w_apply = 1'b1;
            if (w_alpha_step == r_act_target) w_state_nxt = S_DONE;
          end else begin
            w_cnt_inc = 1'b1;
          end
        end
      end
      S_DONE: begin
        w_set_pend  = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_abort) begin
      w_state_nxt = S_IDLE;
      w_capture   = 1'b0;
      w_apply     = 1'b0;
      w_cnt_inc   = 1'b0;
      w_set_pend  = 1'b0;
    end
  end

  // fade datapath: active parameters, frame divider, alpha
  always_ff @(posedge iCLK27 or negedge iRST_N) begin
    if (!iRST_N) begin
      r_act_target <= 10'd0;
      r_act_step   <= 10'd1;
      r_act_div    <= 8'd1;
      r_frame_cnt  <= 8'd0;
      r_alpha      <= ALPHA_RST;
    end else begin
      if (w_capture) begin
        r_act_target <= r_target;
        r_act_step   <= r_step;
        r_act_div    <= r_div;
        r_frame_cnt  <= 8'd0;
      end else if (w_apply) begin
        r_frame_cnt  <= 8'd0;
      end else if (w_cnt_inc) begin
        r_frame_cnt  <= r_frame_cnt + 8'd1;
      end
      if (w_apply) r_alpha <= w_alpha_step;
    end
  end

  // bus-writable registers; zero step/div are stored as 1 so a fade always moves
  always_ff @(posedge iCLK27 or negedge iRST_N) begin
    if (!iRST_N) begin
      r_target <= 10'd0;
      r_step   <= 10'd1;
      r_div    <= 8'd1;
      r_thr    <= THR_RST;
      r_irq_en <= 1'b0;
    end else if (iWrite) begin
      case (iAddress)
        2'd0: r_irq_en <= iWriteData[2];
        2'd1: r_target <= iWriteData[9:0];
        2'd2: begin
          r_step <= (iWriteData[9:0] == 10'd0) ? 10'd1 : iWriteData[9:0];
          r_div  <= (iWriteData[23:16] == 8'd0) ? 8'd1 : iWriteData[23:16];
        end
        default: r_thr <= iWriteData[9:0];
      endcase
    end
  end

  // interrupt pending: the DONE set beats a simultaneous clear
  always_ff @(posedge iCLK27 or negedge iRST_N) begin
    if (!iRST_N)         r_irq_pend <= 1'b0;
    else if (w_set_pend) r_irq_pend <= 1'b1;
    else if (w_irq_clr)  r_irq_pend <= 1'b0;
  end

  // threshold shadow: programmed value reaches the datapath on the frame edge
  always_ff @(posedge iCLK27 or negedge iRST_N) begin
    if (!iRST_N)           r_thr_out <= THR_RST;
    else if (w_frame_tick) r_thr_out <= r_thr;
  end

  // registered read mux, data valid the cycle after iRead
  always_ff @(posedge iCLK27 or negedge iRST_N) begin
    if (!iRST_N) begin
      r_rdata <= 32'd0;
    end else if (iRead) begin
      case (iAddress)
        2'd0:    r_rdata <= {28'd0, r_irq_pend, r_irq_en, r_state};
        2'd1:    r_rdata <= {22'd0, r_target};
        2'd2:    r_rdata <= {8'd0, r_div, 6'd0, r_step};
        default: r_rdata <= {22'd0, r_thr};
      endcase
    end
  end

  assign oReadData      = r_rdata;
  assign oTransparencia = r_alpha;
  assign oThreshold     = r_thr_out;
  assign oBusy          = (r_state != S_IDLE);
  assign oIrq           = r_irq_pend & r_irq_en;

endmodule

// File: tb/tb_chroma_fade_sequencer.sv
// Bench for chroma_fade_sequencer: directed vector table, hand-written corner
// sequences, then random bus/vsync traffic against a frame-level model.
module tb_chroma_fade_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vs_n = 1'b1;
  logic [1:0]  addr = 2'd0;
  logic        wr = 1'b0;
  logic [31:0] wdata = 32'd0;
  logic        rd = 1'b0;
  logic [31:0] rdata;
  logic [9:0]  alpha, thr;
  logic        busy, irq;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  chroma_fade_sequencer dut (
    .iCLK27(clk), .iRST_N(rst_n), .iVSYNC_N(vs_n),
    .iAddress(addr), .iWrite(wr), .iWriteData(wdata), .iRead(rd),
    .oReadData(rdata), .oTransparencia(alpha), .oThreshold(thr),
    .oBusy(busy), .oIrq(irq)
  );

  typedef struct {
    int          op;     // 0 write, 1 read, 2 vsync pulse
    logic [1:0]  a;
    logic [31:0] d;      // write data or expected read data
    logic [9:0]  e_alpha;
    logic [9:0]  e_thr;
    logic        e_busy;
    logic        e_irq;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int op, input logic [1:0] a, input logic [31:0] d,
                     input logic [9:0] al, input logic [9:0] th, input logic b, input logic i);
    vec_t v;
    v.op = op; v.a = a; v.d = d; v.e_alpha = al; v.e_thr = th; v.e_busy = b; v.e_irq = i;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [9:0] al, input logic [9:0] th,
                          input logic b, input logic i);
    chk({tag, " alpha"}, {22'd0, alpha}, {22'd0, al});
    chk({tag, " thr"},   {22'd0, thr},   {22'd0, th});
    chk({tag, " busy"},  {31'd0, busy},  {31'd0, b});
    chk({tag, " irq"},   {31'd0, irq},   {31'd0, i});
  endtask

  // all bus tasks start and end on a falling clock edge
  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    addr = a; wdata = d; wr = 1'b1;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
    addr = a; rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    @(negedge clk);
    d = rdata;
  endtask

  task automatic vsync_pulse();
    vs_n = 1'b0;
    repeat (4) @(negedge clk);
    vs_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // frame-level reference model
  int m_alpha, m_thr_reg, m_thr_out, m_target, m_step, m_div;
  int m_atgt, m_astep, m_adiv, m_frames;
  bit m_en, m_pend, m_run;

  task automatic m_reset();
    m_alpha = 'h3FF; m_thr_reg = 'h1FF; m_thr_out = 'h1FF;
    m_target = 0; m_step = 1; m_div = 1;
    m_atgt = 0; m_astep = 1; m_adiv = 1; m_frames = 0;
    m_en = 0; m_pend = 0; m_run = 0;
  endtask

  task automatic m_write(input int a, input logic [31:0] d);
    case (a)
      0: begin
        m_en = d[2];
        if (d[3]) m_pend = 0;
        if (d[1]) m_run = 0;
        else if (d[0] && !m_run) begin
          m_atgt = m_target; m_astep = m_step; m_adiv = m_div; m_frames = 0;
          if (m_target == m_alpha) m_pend = 1;
          else m_run = 1;
        end
      end
      1: m_target = int'(d[9:0]);
      2: begin
        m_step = (d[9:0] == 0) ? 1 : int'(d[9:0]);
        m_div  = (d[23:16] == 0) ? 1 : int'(d[23:16]);
      end
      default: m_thr_reg = int'(d[9:0]);
    endcase
  endtask

  task automatic m_vsync();
    m_thr_out = m_thr_reg;
    if (m_run) begin
      m_frames++;
      if (m_frames == m_adiv) begin
        m_frames = 0;
        if (m_atgt > m_alpha) m_alpha = (m_alpha + m_astep > m_atgt) ? m_atgt : m_alpha + m_astep;
        else                  m_alpha = (m_alpha - m_astep < m_atgt) ? m_atgt : m_alpha - m_astep;
        if (m_alpha == m_atgt) begin
          m_run = 0;
          m_pend = 1;
        end
      end
    end
  endtask

  function automatic logic [31:0] m_read(input int a);
    case (a)
      0: return {28'd0, m_pend, m_en, 1'b0, m_run};
      1: return 32'(m_target);
      2: return (32'(m_div) << 16) | 32'(m_step);
      default: return 32'(m_thr_reg);
    endcase
  endfunction

  initial begin
    logic [31:0] r;
    // directed table: {op, addr, data/expected read, alpha, thr, busy, irq}
    add(1, 0, 32'h0,        10'h3FF, 10'h1FF, 0, 0);
    add(1, 1, 32'h0,        10'h3FF, 10'h1FF, 0, 0);
    add(1, 2, 32'h00010001, 10'h3FF, 10'h1FF, 0, 0);
    add(1, 3, 32'h1FF,      10'h3FF, 10'h1FF, 0, 0);
    // downward fade, saturating at target
    add(0, 1, 32'h100,      10'h3FF, 10'h1FF, 0, 0);
    add(0, 2, 32'h00010100, 10'h3FF, 10'h1FF, 0, 0);
    add(0, 0, 32'h5,        10'h3FF, 10'h1FF, 1, 0);
    add(2, 0, 0,            10'h2FF, 10'h1FF, 1, 0);
    add(2, 0, 0,            10'h1FF, 10'h1FF, 1, 0);
    add(2, 0, 0,            10'h100, 10'h1FF, 0, 1);
    add(2, 0, 0,            10'h100, 10'h1FF, 0, 1);
    add(1, 0, 32'hC,        10'h100, 10'h1FF, 0, 1);
    add(0, 0, 32'hC,        10'h100, 10'h1FF, 0, 0);
    // upward fade with DIV=3, no wrap past 3FF
    add(0, 1, 32'h3FF,      10'h100, 10'h1FF, 0, 0);
    add(0, 2, 32'h00030200, 10'h100, 10'h1FF, 0, 0);
    add(0, 0, 32'h5,        10'h100, 10'h1FF, 1, 0);
    add(2, 0, 0,            10'h100, 10'h1FF, 1, 0);
    add(2, 0, 0,            10'h100, 10'h1FF, 1, 0);
    add(2, 0, 0,            10'h300, 10'h1FF, 1, 0);
    add(2, 0, 0,            10'h300, 10'h1FF, 1, 0);
    add(2, 0, 0,            10'h300, 10'h1FF, 1, 0);
    add(2, 0, 0,            10'h3FF, 10'h1FF, 0, 1);
    add(0, 0, 32'hC,        10'h3FF, 10'h1FF, 0, 0);
    // abort after two single steps
    add(0, 1, 32'h0,        10'h3FF, 10'h1FF, 0, 0);
    add(0, 2, 32'h00010001, 10'h3FF, 10'h1FF, 0, 0);
    add(0, 0, 32'h5,        10'h3FF, 10'h1FF, 1, 0);
    add(2, 0, 0,            10'h3FE, 10'h1FF, 1, 0);
    add(2, 0, 0,            10'h3FD, 10'h1FF, 1, 0);
    add(0, 0, 32'h6,        10'h3FD, 10'h1FF, 0, 0);
    add(2, 0, 0,            10'h3FD, 10'h1FF, 0, 0);
    add(1, 0, 32'h4,        10'h3FD, 10'h1FF, 0, 0);
    // writes during RUN leave the active fade alone
    add(0, 1, 32'h3FB,      10'h3FD, 10'h1FF, 0, 0);
    add(0, 0, 32'h5,        10'h3FD, 10'h1FF, 1, 0);
    add(2, 0, 0,            10'h3FC, 10'h1FF, 1, 0);
    add(0, 1, 32'h0,        10'h3FC, 10'h1FF, 1, 0);
    add(0, 0, 32'h5,        10'h3FC, 10'h1FF, 1, 0);
    add(2, 0, 0,            10'h3FB, 10'h1FF, 0, 1);
    add(2, 0, 0,            10'h3FB, 10'h1FF, 0, 1);
    add(1, 1, 32'h0,        10'h3FB, 10'h1FF, 0, 1);
    add(0, 0, 32'hC,        10'h3FB, 10'h1FF, 0, 0);
    // threshold is shadowed until the frame edge
    add(0, 3, 32'h080,      10'h3FB, 10'h1FF, 0, 0);
    add(1, 3, 32'h080,      10'h3FB, 10'h1FF, 0, 0);
    add(2, 0, 0,            10'h3FB, 10'h080, 0, 0);
    // zero step/div stored as 1
    add(0, 2, 32'h0,        10'h3FB, 10'h080, 0, 0);
    add(1, 2, 32'h00010001, 10'h3FB, 10'h080, 0, 0);

    repeat (3) @(negedge clk);
    chk_outs("reset", 10'h3FF, 10'h1FF, 0, 0);
    chk("reset rdata", rdata, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (tbl[k]) begin
      string tag;
      tag = $sformatf("vec%0d", k);
      case (tbl[k].op)
        0: bus_wr(tbl[k].a, tbl[k].d);
        1: begin
          bus_rd(tbl[k].a, r);
          chk({tag, " rdata"}, r, tbl[k].d);
        end
        default: vsync_pulse();
      endcase
      chk_outs(tag, tbl[k].e_alpha, tbl[k].e_thr, tbl[k].e_busy, tbl[k].e_irq);
    end

    // TARGET equal to alpha: DONE the next cycle, irq the one after
    bus_wr(1, 32'h3FB);
    bus_wr(0, 32'h5);
    chk("eq busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("eq irq", {31'd0, irq}, 32'd1);
    chk("eq idle", {31'd0, busy}, 32'd0);
    bus_wr(0, 32'hC);
    chk("clr irq", {31'd0, irq}, 32'd0);
    // clear lands in the same cycle as the DONE set: set wins
    bus_wr(0, 32'h5);
    bus_wr(0, 32'hC);
    chk("set beats clr", {31'd0, irq}, 32'd1);
    bus_rd(0, r);
    chk("set beats clr ctrl", r, 32'hC);

    // asynchronous reset in the middle of a fade
    bus_wr(1, 32'h0);
    bus_wr(2, 32'h00010010);
    bus_wr(0, 32'h5);
    vsync_pulse();
    chk("midfade alpha", {22'd0, alpha}, 32'h3EB);
    #2 rst_n = 1'b0;
    #1;
    chk_outs("async rst", 10'h3FF, 10'h1FF, 0, 0);
    chk("async rst rdata", rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // random traffic against the model
    m_reset();
    for (int it = 0; it < 500; it++) begin
      int sel, a;
      logic [31:0] d;
      string tag;
      tag = $sformatf("rnd%0d", it);
      sel = $urandom_range(0, 9);
      d = $urandom;
      case (sel)
        0, 1, 9: begin
          vsync_pulse();
          m_vsync();
        end
        2, 3: begin
          d[1] = ($urandom_range(0, 7) == 0);
          d[0] = ($urandom_range(0, 2) != 0);
          bus_wr(0, d);
          m_write(0, d);
          @(negedge clk);  // let a zero-length DONE finish
        end
        4: begin bus_wr(1, d); m_write(1, d); end
        5: begin
          d[23:16] = 8'($urandom_range(0, 3));
          if ($urandom_range(0, 1) == 0) d[9:0] = 10'($urandom_range(0, 64));
          bus_wr(2, d);
          m_write(2, d);
        end
        6: begin bus_wr(3, d); m_write(3, d); end
        default: begin
          a = $urandom_range(0, 3);
          bus_rd(2'(a), r);
          chk({tag, " rdata"}, r, m_read(a));
        end
      endcase
      chk_outs(tag, 10'(m_alpha), 10'(m_thr_out), m_run, m_pend & m_en);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
